// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data types, decoder states,
// header ECC column table, CRC constants and ECC helper.
package mipi_csi_pkg;

  localparam logic [5:0] DT_FSC   = 6'h00;
  localparam logic [5:0] DT_FEC   = 6'h01;
  localparam logic [5:0] DT_LSC   = 6'h02;
  localparam logic [5:0] DT_LEC   = 6'h03;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  localparam logic [15:0] CRC_SEED = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC,
    DRAIN
  } state_t;

  // Parity contribution {P5..P0} of each header bit D[i]
  localparam logic [5:0] ECC_COL [0:23] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15,
    6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32,
    6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 24; i++) begin
      if (d[i]) p = p ^ ECC_COL[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/csi_crc16_byte4.sv
// Combinational CRC-16 (reflected x^16+x^12+x^5+1) step over up to
// four bytes, byte0 first, each byte LSB-first; en[3] gates byte0.
module csi_crc16_byte4
  import mipi_csi_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  en,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int k = 0; k < 4; k++) begin
      if (en[3-k]) begin
        crc_out = crc_out ^ {8'h00, data[31-8*k -: 8]};
        for (int b = 0; b < 8; b++) begin
          crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY)
                               : (crc_out >> 1);
        end
      end
    end
  end

endmodule

// File: rtl/csi_packet_decoder.sv
// CSI-2 packet decoder: header ECC check/correct, short/long split,
// payload streaming with byte enables and payload CRC check.
module csi_packet_decoder
  import mipi_csi_pkg::*;
#(
  parameter int         MIPI_LANES   = 4,
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  output logic        header_valid_o,
  output logic        header_short_o,
  output logic [1:0]  header_vc_o,
  output logic [5:0]  header_dt_o,
  output logic [15:0] header_wc_o,
  output logic        payload_valid_o,
  output logic [31:0] payload_data_o,
  output logic [3:0]  payload_byte_en_o,
  output logic        payload_last_o,
  output logic        crc_valid_o,
  output logic        err_crc_o,
  output logic        err_ecc_corrected_o,
  output logic        err_ecc_double_o,
  output logic        err_eot_o
);

  if (MIPI_LANES != 4) begin : g_lanes_chk
    $error("csi_packet_decoder: only MIPI_LANES=4 is supported");
  end

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        need1_q, need1_d;

  logic [7:0]  byte_w [4];
  logic [23:0] hdr_raw, hdr_fix;
  logic [5:0]  syn;
  logic        col_hit;
  logic        hdr_short;
  logic [3:0]  pay_en;
  logic        pay_last;
  logic [15:0] crc_step;

  logic        hv_d, hs_d, pv_d, pl_d;
  logic        cv_d, ec_d, cor_d, dbl_d, eot_d;
  logic [1:0]  vc_d;
  logic [5:0]  dt_d;
  logic [15:0] wc_d;
  logic [31:0] pd_d;
  logic [3:0]  be_d;

  assign byte_w[0] = data_i[31:24];
  assign byte_w[1] = data_i[23:16];
  assign byte_w[2] = data_i[15:8];
  assign byte_w[3] = data_i[7:0];

  assign hdr_raw   = {data_i[15:8], data_i[23:16], data_i[31:24]};
  assign syn       = ecc_calc(hdr_raw) ^ data_i[5:0];
  assign hdr_short = hdr_fix[5:0] <= SHORT_DT_MAX;

  always_comb begin
    hdr_fix = hdr_raw;
    col_hit = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (syn == ECC_COL[i]) begin
        hdr_fix[i] = ~hdr_raw[i];
        col_hit    = 1'b1;
      end
    end
  end

  assign pay_last = cnt_q <= 16'd4;

  always_comb begin
    unique case (1'b1)
      cnt_q > 16'd3:  pay_en = 4'b1111;
      cnt_q == 16'd3: pay_en = 4'b1110;
      cnt_q == 16'd2: pay_en = 4'b1100;
      default:        pay_en = 4'b1000;
    endcase
  end

  csi_crc16_byte4 u_crc (
    .crc_in  (crc_q),
    .data    (data_i),
    .en      (pay_en),
    .crc_out (crc_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    crc_lo_d = crc_lo_q;
    need1_d  = need1_q;
    hv_d     = 1'b0;
    hs_d     = header_short_o;
    vc_d     = header_vc_o;
    dt_d     = header_dt_o;
    wc_d     = header_wc_o;
    pv_d     = 1'b0;
    pd_d     = payload_data_o;
    be_d     = 4'b0000;
    pl_d     = 1'b0;
    cv_d     = 1'b0;
    ec_d     = 1'b0;
    cor_d    = 1'b0;
    dbl_d    = 1'b0;
    eot_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (syn != 6'd0 && !col_hit && !$onehot(syn)) begin
            dbl_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            cor_d   = syn != 6'd0;
            hv_d    = 1'b1;
            hs_d    = hdr_short;
            vc_d    = hdr_fix[7:6];
            dt_d    = hdr_fix[5:0];
            wc_d    = hdr_fix[23:8];
            cnt_d   = hdr_fix[23:8];
            crc_d   = CRC_SEED;
            need1_d = 1'b0;
            if (hdr_short)                   state_d = DRAIN;
            else if (hdr_fix[23:8] == 16'd0) state_d = CRC;
            else                             state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!valid_i) begin
          eot_d   = 1'b1;
          state_d = IDLE;
        end else begin
          pv_d  = 1'b1;
          pd_d  = data_i;
          be_d  = pay_en;
          pl_d  = pay_last;
          crc_d = crc_step;
          cnt_d = pay_last ? 16'd0 : cnt_q - 16'd4;
          if (pay_last) begin
            // Bytes left over after the payload carry the CRC
            unique case (cnt_q[2:0])
              3'd1: begin
                cv_d    = 1'b1;
                ec_d    = {byte_w[2], byte_w[1]} != crc_step;
                state_d = DRAIN;
              end
              3'd2: begin
                cv_d    = 1'b1;
                ec_d    = {byte_w[3], byte_w[2]} != crc_step;
                state_d = DRAIN;
              end
              3'd3: begin
                crc_lo_d = byte_w[3];
                need1_d  = 1'b1;
                state_d  = CRC;
              end
              default: begin
                need1_d = 1'b0;
                state_d = CRC;
              end
            endcase
          end
        end
      end
      CRC: begin
        if (!valid_i) begin
          eot_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cv_d    = 1'b1;
          ec_d    = need1_q ? ({byte_w[0], crc_lo_q} != crc_q)
                            : ({byte_w[1], byte_w[0]} != crc_q);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      crc_q               <= CRC_SEED;
      crc_lo_q            <= '0;
      need1_q             <= 1'b0;
      header_valid_o      <= 1'b0;
      header_short_o      <= 1'b0;
      header_vc_o         <= '0;
      header_dt_o         <= '0;
      header_wc_o         <= '0;
      payload_valid_o     <= 1'b0;
      payload_data_o      <= '0;
      payload_byte_en_o   <= '0;
      payload_last_o      <= 1'b0;
      crc_valid_o         <= 1'b0;
      err_crc_o           <= 1'b0;
      err_ecc_corrected_o <= 1'b0;
      err_ecc_double_o    <= 1'b0;
      err_eot_o           <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      crc_q               <= crc_d;
      crc_lo_q            <= crc_lo_d;
      need1_q             <= need1_d;
      header_valid_o      <= hv_d;
      header_short_o      <= hs_d;
      header_vc_o         <= vc_d;
      header_dt_o         <= dt_d;
      header_wc_o         <= wc_d;
      payload_valid_o     <= pv_d;
      payload_data_o      <= pd_d;
      payload_byte_en_o   <= be_d;
      payload_last_o      <= pl_d;
      crc_valid_o         <= cv_d;
      err_crc_o           <= ec_d;
      err_ecc_corrected_o <= cor_d;
      err_ecc_double_o    <= dbl_d;
      err_eot_o           <= eot_d;
    end
  end

endmodule

// File: tb/tb_csi_packet_decoder.sv
// Scoreboard bench for csi_packet_decoder: packets are built from
// fields, expected events queued at drive time and popped on output.
module tb_csi_packet_decoder;

  localparam logic [2:0] K_ECOR = 3'd1;
  localparam logic [2:0] K_EDBL = 3'd2;
  localparam logic [2:0] K_HDR  = 3'd3;
  localparam logic [2:0] K_PAY  = 3'd4;
  localparam logic [2:0] K_CRC  = 3'd5;
  localparam logic [2:0] K_EOT  = 3'd6;

  typedef struct {
    logic [2:0]  k;
    logic [63:0] v;
  } ev_t;

  logic        clk;
  logic        reset_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        header_valid_o, header_short_o;
  logic [1:0]  header_vc_o;
  logic [5:0]  header_dt_o;
  logic [15:0] header_wc_o;
  logic        payload_valid_o;
  logic [31:0] payload_data_o;
  logic [3:0]  payload_byte_en_o;
  logic        payload_last_o, crc_valid_o, err_crc_o;
  logic        err_ecc_corrected_o, err_ecc_double_o, err_eot_o;
  logic [68:0] outs;

  int          checks = 0;
  int          errors = 0;
  ev_t         sb [$];
  logic [7:0]  pay [$];

  csi_packet_decoder dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .valid_i             (valid_i),
    .data_i              (data_i),
    .header_valid_o      (header_valid_o),
    .header_short_o      (header_short_o),
    .header_vc_o         (header_vc_o),
    .header_dt_o         (header_dt_o),
    .header_wc_o         (header_wc_o),
    .payload_valid_o     (payload_valid_o),
    .payload_data_o      (payload_data_o),
    .payload_byte_en_o   (payload_byte_en_o),
    .payload_last_o      (payload_last_o),
    .crc_valid_o         (crc_valid_o),
    .err_crc_o           (err_crc_o),
    .err_ecc_corrected_o (err_ecc_corrected_o),
    .err_ecc_double_o    (err_ecc_double_o),
    .err_eot_o           (err_eot_o)
  );

  assign outs = {header_valid_o, header_short_o, header_vc_o,
                 header_dt_o, header_wc_o, payload_valid_o,
                 payload_data_o, payload_byte_en_o, payload_last_o,
                 crc_valid_o, err_crc_o, err_ecc_corrected_o,
                 err_ecc_double_o, err_eot_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [2:0] k, input logic [63:0] v);
    ev_t e;
    e.k = k;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [2:0] k, input logic [63:0] v,
                        input string tag);
    ev_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 72'd1, 72'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, {k, v}, {e.k, e.v});
    end
  endtask

  always @(negedge clk) begin
    if (err_ecc_corrected_o) sb_pop(K_ECOR, 64'd0, "ecc_cor");
    if (err_ecc_double_o)    sb_pop(K_EDBL, 64'd0, "ecc_dbl");
    if (header_valid_o)
      sb_pop(K_HDR, {39'd0, header_short_o, header_vc_o,
                     header_dt_o, header_wc_o}, "hdr");
    if (payload_valid_o)
      sb_pop(K_PAY, {27'd0, payload_data_o, payload_byte_en_o,
                     payload_last_o}, "pay");
    if (crc_valid_o)         sb_pop(K_CRC, {63'd0, err_crc_o}, "crc");
    if (err_eot_o)           sb_pop(K_EOT, 64'd0, "eot");
  end

  function automatic logic [5:0] ecc_ref(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]
         ^ d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]
         ^ d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]
         ^ d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]
         ^ d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]
         ^ d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]
         ^ d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, pay[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    valid_i = v;
    data_i  = d;
  endtask

  // flip[23:0] corrupts header bits, flip[29:24] the ECC bits.
  // cut >= 0 sends only that many words after the header.
  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input logic [29:0] flip,
                          input int bad, input bit ovr,
                          input logic [15:0] ovr_crc, input bit exp_err,
                          input int cut, input int trail,
                          input bit rst_cut);
    logic [23:0] h, htx;
    logic [7:0]  st [$];
    logic [15:0] c;
    logic [31:0] w;
    logic [3:0]  be;
    bit          long_pk, ok, trunc;
    int          nflip, nw, nwp, cw, r;
    h       = {wc, vc, dt};
    htx     = h ^ flip[23:0];
    long_pk = dt > 6'h0F;
    nflip   = $countones(flip);
    ok      = nflip < 2;
    st.push_back(htx[7:0]);
    st.push_back(htx[15:8]);
    st.push_back(htx[23:16]);
    st.push_back({2'b00, ecc_ref(h) ^ flip[29:24]});
    if (nflip == 1) exp_push(K_ECOR, 64'd0);
    if (!ok) exp_push(K_EDBL, 64'd0);
    else exp_push(K_HDR, {39'd0, ~long_pk, vc, dt, wc});
    if (long_pk) begin
      c = ovr ? ovr_crc : crc_ref(int'(wc));
      for (int i = 0; i < int'(wc); i++)
        st.push_back(i == bad ? pay[i] ^ 8'h01 : pay[i]);
      st.push_back(c[7:0]);
      st.push_back(c[15:8]);
      while (st.size() % 4 != 0) st.push_back(8'hFF);
    end
    nw    = st.size() / 4;
    nwp   = (int'(wc) + 3) / 4;
    cw    = (int'(wc) + 5) / 4;
    trunc = long_pk && ok && cut >= 0 && cut < cw;
    for (int i = 0; i < nw; i++) begin
      if (cut >= 0 && i > cut) break;
      w = {st[4*i], st[4*i+1], st[4*i+2], st[4*i+3]};
      if (i > 0 && long_pk && ok) begin
        if (i <= nwp) begin
          r  = int'(wc) - 4 * (i - 1);
          be = r >= 4 ? 4'hF : r == 3 ? 4'hE : r == 2 ? 4'hC : 4'h8;
          exp_push(K_PAY, {27'd0, w, be, i == nwp});
        end
        if (i == cw) exp_push(K_CRC, {63'd0, exp_err});
      end
      drive(1'b1, w);
    end
    if (rst_cut) begin
      @(posedge clk);
      #7;
      reset_i = 1'b1;
      valid_i = 1'b0;
      data_i  = '0;
      #1 chk("rst_mid_outs", outs, 72'd0);
      @(posedge clk);
      #1 reset_i = 1'b0;
      return;
    end
    if (trunc) exp_push(K_EOT, 64'd0);
    else for (int i = 0; i < trail; i++) drive(1'b1, 32'hFFFF_FFFF);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
  endtask

  initial begin
    int wcs [7];
    logic [15:0] rw;
    wcs       = '{6, 7, 8, 5, 1, 0, 4};
    valid_i   = 1'b0;
    data_i    = '0;
    reset_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", outs, 72'd0);
    reset_i = 1'b0;
    drive(1'b0, 32'h0);

    send_pkt(2'd0, 6'h00, 16'h0001, '0, -1, 0, '0, 0, -1, 2, 0);

    pay = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
            8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
            8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    send_pkt(2'd0, 6'h2A, 16'd24, '0, -1, 1, 16'h00F0, 0, -1, 1, 0);
    send_pkt(2'd0, 6'h2A, 16'd24, '0, 5, 1, 16'h00F0, 1, -1, 0, 0);

    foreach (wcs[i]) begin
      fill_pay(wcs[i]);
      send_pkt(2'd1, 6'h2B, 16'(wcs[i]), '0, -1, 0, '0, 0, -1, 1, 0);
    end

    fill_pay(6);
    send_pkt(2'd2, 6'h2A, 16'd6, 30'h400, -1, 0, '0, 0, -1, 0, 0);
    send_pkt(2'd3, 6'h02, 16'hA5C3, 30'h4000000, -1, 0, '0, 0, -1, 0, 0);
    fill_pay(8);
    send_pkt(2'd0, 6'h2A, 16'd8, 30'h1008, -1, 0, '0, 0, -1, 0, 0);
    send_pkt(2'd1, 6'h02, 16'h1234, '0, -1, 0, '0, 0, -1, 0, 0);

    fill_pay(12);
    send_pkt(2'd0, 6'h2A, 16'd12, '0, -1, 0, '0, 0, 1, 0, 0);
    fill_pay(12);
    send_pkt(2'd0, 6'h2A, 16'd12, '0, -1, 0, '0, 0, 1, 0, 1);
    drive(1'b0, 32'h0);
    fill_pay(10);
    send_pkt(2'd2, 6'h2B, 16'd10, '0, -1, 0, '0, 0, -1, 1, 0);

    for (int n = 0; n < 6; n++) begin
      rw = 16'($urandom_range(1, 40));
      fill_pay(int'(rw));
      send_pkt(2'($urandom), 6'($urandom_range(16, 63)), rw, '0, -1,
               0, '0, 0, -1, $urandom_range(0, 2), 0);
    end

    fill_pay(65535);
    send_pkt(2'd1, 6'h2A, 16'hFFFF, '0, -1, 0, '0, 0, -1, 0, 0);

    repeat (5) drive(1'b0, 32'h0);
    chk("sb_empty", 72'(sb.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
